// File: rtl/fifo_stream_rd_adapter_pkg.sv
// fifo_stream_rd_adapter_pkg: shared sizing helpers for the FIFO read-side stream adapter.
// Rev 1.0
`default_nettype none

package fifo_stream_rd_adapter_pkg;

    // Ceiling log2 that never returns less than 1, so a one-entry count still gets a bit.
    function automatic int clog2s(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: circular register buffer with push/pop and occupancy; head word is combinational.
// Rev 1.0
`default_nettype none

module stream_skid_buf
    import fifo_stream_rd_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 3,
    parameter int OCC_WIDTH  = clog2s(BUF_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [OCC_WIDTH-1:0]  occ_o
);

    localparam int PTR_WIDTH = clog2s(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic                  pop;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (occ_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
    assign pop     = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_i && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_rd_adapter.sv
// fifo_stream_rd_adapter: credit-based reader turning a registered FIFO read port into a FWFT valid/ready stream.
// Rev 1.0
`default_nettype none

module fifo_stream_rd_adapter
    import fifo_stream_rd_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 2,
    parameter int CNT_WIDTH  = clog2s(BUF_DEPTH + 1)
) (
    input  logic                  RD_CLK,
    input  logic                  RD_RST,
    output logic                  FIFO_RD_EN,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  FIFO_RD_EMPTY,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic [CNT_WIDTH-1:0]  LEVEL
);

    logic [RD_LATENCY-1:0] infl_q, infl_d;
    logic [CNT_WIDTH-1:0]  occ;
    logic [CNT_WIDTH-1:0]  inflight;
    logic [CNT_WIDTH:0]    credit_used;
    logic [CNT_WIDTH-1:0]  level_q, level_d;
    logic                  land;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_WIDTH'(infl_q[i]);
        end
    end

    // Credit uses registered occupancy only; a pop in this cycle frees a slot next cycle.
    assign credit_used = {1'b0, occ} + {1'b0, inflight};
    assign FIFO_RD_EN  = !RD_RST && !FIFO_RD_EMPTY
                         && (credit_used < (CNT_WIDTH + 1)'(BUF_DEPTH));

    always_comb begin
        infl_d    = infl_q << 1;
        infl_d[0] = FIFO_RD_EN;
    end

    assign land = infl_q[RD_LATENCY-1];

    always_comb begin
        level_d = credit_used[CNT_WIDTH-1:0];
        if (credit_used > (CNT_WIDTH + 1)'(BUF_DEPTH)) begin
            level_d = CNT_WIDTH'(BUF_DEPTH);
        end
    end

    always_ff @(posedge RD_CLK or posedge RD_RST) begin
        if (RD_RST) begin
            infl_q  <= '0;
            level_q <= '0;
        end else begin
            infl_q  <= infl_d;
            level_q <= level_d;
        end
    end

    assign LEVEL = level_q;

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .OCC_WIDTH  (CNT_WIDTH)
    ) u_buf (
        .clk_i       (RD_CLK),
        .rst_i       (RD_RST),
        .push_i      (land),
        .push_data_i (FIFO_RD_DATA),
        .pop_i       (M_READY),
        .valid_o     (M_VALID),
        .data_o      (M_DATA),
        .occ_o       (occ)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_rd_adapter.sv
// tb_fifo_stream_rd_adapter: scoreboard bench; two lanes (RD_LATENCY 1/depth 3 and RD_LATENCY 2/depth 4).
// Rev 1.0
`default_nettype none

module tb_fifo_stream_rd_adapter;

    localparam int DW = 32;

    logic RD_CLK  = 1'b0;
    logic RD_RST  = 1'b1;
    logic M_READY = 1'b0;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int ready_mode = 1;
    bit chk_lat    = 1'b0;

    // Every word the writer has put into the FIFO, in write order: the expected stream.
    logic [DW-1:0] words[$];

    always #5 RD_CLK = ~RD_CLK;

    always @(posedge RD_CLK) cyc = cyc + 1;

    initial begin
        forever begin
            @(posedge RD_CLK);
            #1;
            case (ready_mode)
                0:       M_READY = 1'b0;
                1:       M_READY = 1'b1;
                default: M_READY = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int LAT   = k + 1;
        localparam int DEPTH = LAT + 2;
        localparam int CW    = $clog2(DEPTH + 1);

        logic          rd_en;
        logic          m_valid;
        logic          empty_r = 1'b1;
        logic [DW-1:0] rd_data;
        logic [DW-1:0] m_data;
        logic [CW-1:0] level;
        logic [DW-1:0] pipe [LAT];
        logic [DW-1:0] fifo_q[$];
        logic [DW-1:0] word;
        logic [DW-1:0] prev_data = '0;
        int            wr_idx    = 0;
        int            exp_idx   = 0;
        int            en_cnt    = 0;
        int            first_en  = -1;
        int            first_v   = -1;
        int            run_len   = 0;
        bit            run_done  = 1'b0;
        bit            prev_hold = 1'b0;

        assign rd_data = pipe[LAT-1];

        fifo_stream_rd_adapter #(
            .DATA_WIDTH (DW),
            .RD_LATENCY (LAT),
            .BUF_DEPTH  (DEPTH),
            .CNT_WIDTH  (CW)
        ) u_dut (
            .RD_CLK        (RD_CLK),
            .RD_RST        (RD_RST),
            .FIFO_RD_EN    (rd_en),
            .FIFO_RD_DATA  (rd_data),
            .FIFO_RD_EMPTY (empty_r),
            .M_VALID       (m_valid),
            .M_READY       (M_READY),
            .M_DATA        (m_data),
            .LEVEL         (level)
        );

        // Standard-mode FIFO read port: registered data RD_LATENCY cycles after a granted read.
        always @(posedge RD_CLK or posedge RD_RST) begin
            if (RD_RST) begin
                fifo_q.delete();
                wr_idx = words.size();
                empty_r <= 1'b1;
                for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            end else begin
                word = 32'hDEAD_BEEF;
                if (rd_en) begin
                    checks++;
                    if (empty_r) begin
                        errors++;
                        $display("FAIL lane%0d rd_en_while_empty: rd_en=1 empty=1 required rd_en=0", k);
                    end
                    if (fifo_q.size() > 0) word = fifo_q.pop_front();
                end
                pipe[0] <= word;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                while (wr_idx < words.size()) begin
                    fifo_q.push_back(words[wr_idx]);
                    wr_idx++;
                end
                empty_r <= (fifo_q.size() == 0);
            end
        end

        always @(negedge RD_CLK) begin
            if (RD_RST) begin
                exp_idx   = words.size();
                prev_hold = 1'b0;
            end else begin
                if (rd_en) en_cnt++;
                if (m_valid && M_READY) begin
                    checks++;
                    if (exp_idx >= words.size()) begin
                        errors++;
                        $display("FAIL lane%0d extra_beat: got %h required no beat", k, m_data);
                    end else begin
                        if (m_data !== words[exp_idx]) begin
                            errors++;
                            $display("FAIL lane%0d order[%0d]: got %h required %h",
                                     k, exp_idx, m_data, words[exp_idx]);
                        end
                        exp_idx++;
                    end
                end
                if (prev_hold) begin
                    checks++;
                    if (!m_valid || m_data !== prev_data) begin
                        errors++;
                        $display("FAIL lane%0d hold_stable: got valid=%0b data=%h required valid=1 data=%h",
                                 k, m_valid, m_data, prev_data);
                    end
                end
                prev_hold = m_valid && !M_READY;
                prev_data = m_data;
                checks++;
                if (int'(level) > DEPTH) begin
                    errors++;
                    $display("FAIL lane%0d level_bound: got %0d required <= %0d", k, level, DEPTH);
                end
                if (chk_lat) begin
                    if (first_en < 0 && rd_en) first_en = cyc;
                    if (first_v < 0 && m_valid) begin
                        first_v = cyc;
                        run_len = 1;
                        checks++;
                        if (first_en < 0 || first_v - first_en != LAT + 1) begin
                            errors++;
                            $display("FAIL lane%0d first_latency: got %0d required %0d",
                                     k, first_v - first_en, LAT + 1);
                        end
                    end else if (first_v >= 0 && !run_done) begin
                        if (m_valid) begin
                            run_len++;
                        end else begin
                            run_done = 1'b1;
                            checks++;
                            if (run_len != 16) begin
                                errors++;
                                $display("FAIL lane%0d burst_length: got %0d required 16", k, run_len);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " lane0 valid"}, 64'(g_lane[0].m_valid), 0);
        check({tag, " lane0 data"},  64'(g_lane[0].m_data), 0);
        check({tag, " lane0 level"}, 64'(g_lane[0].level), 0);
        check({tag, " lane0 rd_en"}, 64'(g_lane[0].rd_en), 0);
        check({tag, " lane1 valid"}, 64'(g_lane[1].m_valid), 0);
        check({tag, " lane1 data"},  64'(g_lane[1].m_data), 0);
        check({tag, " lane1 level"}, 64'(g_lane[1].level), 0);
        check({tag, " lane1 rd_en"}, 64'(g_lane[1].rd_en), 0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((g_lane[0].exp_idx != words.size() || g_lane[1].exp_idx != words.size()) && n < budget) begin
            @(negedge RD_CLK);
            n++;
        end
        check({name, " lane0 drained"}, 64'(g_lane[0].exp_idx), 64'(words.size()));
        check({name, " lane1 drained"}, 64'(g_lane[1].exp_idx), 64'(words.size()));
        repeat (3) @(negedge RD_CLK);
        check({name, " lane0 idle"}, 64'(g_lane[0].m_valid), 0);
        check({name, " lane1 idle"}, 64'(g_lane[1].m_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, n, gaps0, gaps1;

        // Reset, then a 16-word preloaded stream with M_READY held high.
        RD_RST     = 1'b1;
        ready_mode = 1;
        repeat (3) @(posedge RD_CLK);
        @(negedge RD_CLK);
        check_idle("reset");
        #2 RD_RST = 1'b0;
        chk_lat = 1'b1;
        for (int i = 1; i <= 16; i++) words.push_back(DW'(i));
        repeat (40) @(negedge RD_CLK);
        chk_lat = 1'b0;
        check("stream lane0 burst seen", 64'(g_lane[0].run_done), 1);
        check("stream lane1 burst seen", 64'(g_lane[1].run_done), 1);
        wait_drain("stream", 50);

        // Full back-pressure: exactly BUF_DEPTH reads, head word held.
        ready_mode = 0;
        repeat (2) @(negedge RD_CLK);
        e0 = g_lane[0].en_cnt;
        e1 = g_lane[1].en_cnt;
        for (int i = 1; i <= 8; i++) words.push_back(DW'(i));
        repeat (20) @(negedge RD_CLK);
        check("bp lane0 reads", 64'(g_lane[0].en_cnt - e0), 3);
        check("bp lane1 reads", 64'(g_lane[1].en_cnt - e1), 4);
        check("bp lane0 level", 64'(g_lane[0].level), 3);
        check("bp lane1 level", 64'(g_lane[1].level), 4);
        check("bp lane0 head",  64'(g_lane[0].m_data), 1);
        check("bp lane1 head",  64'(g_lane[1].m_data), 1);
        check("bp lane0 valid", 64'(g_lane[0].m_valid), 1);
        ready_mode = 1;
        wait_drain("bp", 100);

        // Random back-pressure with a bursty writer.
        ready_mode = 2;
        n = 0;
        while (n < 1000) begin
            @(negedge RD_CLK);
            if ($urandom_range(0, 1) == 1) begin
                words.push_back($urandom);
                n++;
            end
        end
        ready_mode = 1;
        wait_drain("random", 3000);

        // Intermittent empty: one word every 4 cycles.
        gaps0 = 0;
        gaps1 = 0;
        for (int i = 0; i < 20; i++) begin
            words.push_back(32'h4000_0000 + DW'(i));
            repeat (4) begin
                @(negedge RD_CLK);
                if (!g_lane[0].m_valid) gaps0++;
                if (!g_lane[1].m_valid) gaps1++;
            end
        end
        check("trickle lane0 gaps", 64'(gaps0 > 0), 1);
        check("trickle lane1 gaps", 64'(gaps1 > 0), 1);
        wait_drain("trickle", 50);

        // Reset mid-stream while lane0 holds two words with one read in flight.
        ready_mode = 0;
        repeat (2) @(negedge RD_CLK);
        for (int i = 0; i < 8; i++) words.push_back(32'h5000_0000 + DW'(i));
        n = 0;
        while (!g_lane[0].rd_en && n < 20) begin
            @(negedge RD_CLK);
            n++;
        end
        check("midrst first read seen", 64'(g_lane[0].rd_en), 1);
        repeat (3) @(negedge RD_CLK);
        check("midrst lane0 valid before", 64'(g_lane[0].m_valid), 1);
        #2 RD_RST = 1'b1;
        #1;
        check_idle("midrst");
        repeat (3) begin
            @(negedge RD_CLK);
            check("midrst lane0 no read", 64'(g_lane[0].rd_en), 0);
            check("midrst lane1 no read", 64'(g_lane[1].rd_en), 0);
        end
        #2 RD_RST = 1'b0;
        for (int i = 0; i < 6; i++) words.push_back(32'hA000_0000 + DW'(i));
        ready_mode = 1;
        wait_drain("post-reset", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
